sha3_absorb_ctrl: RTL and testbench
===================================

SHA3_ABSORB_CTRL -- requirements
Module: sha3_absorb_ctrl

Interface
REQ-001 Parameter: DATA_SIZE, default 64, lane/FIFO word width in bits; only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  begin hashing one message; sampled only in IDLE.
REQ-005 mode  input  3  0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512, 4=SHAKE128, 5=SHAKE256; latched on accepted start.
REQ-006 msg_len  input  16  message length in bytes; latched on accepted start.
REQ-007 fifo_empty  input  1  input FIFO empty flag.
REQ-008 fifo_rd_data  input  64  show-ahead FIFO head word; byte i at bits [8i+7:8i].
REQ-009 fifo_rd_en  output  1  pop FIFO head this cycle.
REQ-010 lane_wr_en  output  1  lane_data is XORed into state lane lane_idx this cycle.
REQ-011 lane_idx  output  5  target lane, 0..rate-1.
REQ-012 lane_data  output  64  message/padding lane value.
REQ-013 perm_start  output  1  one-cycle pulse launching Keccak-f permutation.
REQ-014 perm_done  input  1  one-cycle pulse: permutation complete.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse after final permutation completes.
REQ-017 err  output  1  one-cycle pulse when start is rejected for an unsupported mode.

Function
REQ-018 Rate in lanes: 224->18, 256->17, 384->13, 512->9, SHAKE128->21, SHAKE256->17.
REQ-019 Words to read: W = ceil(msg_len/8); tail bytes k = msg_len mod 8; domain byte D = 0x06 (SHA3) or 0x1F (SHAKE).
REQ-020 States: IDLE, ABSORB, PAD, PERM, FIN; IDLE->ABSORB on start (valid mode), ->PAD directly if W==0.
REQ-021 ABSORB: when !fifo_empty, fifo_rd_en, lane_wr_en asserted same cycle, lane_data from fifo_rd_data (zero added latency); no read/write while fifo_empty.
REQ-022 Final word with k!=0: bytes >=k zeroed, byte k = D; then PAD; with k==0, byte D placed at byte 0 of the next lane in PAD.
REQ-023 PAD: one lane per cycle, no stalls, remaining lanes up to rate-1 written, zero except pad bytes; lane rate-1 byte 7 ORed with 0x80 (D in same byte yields 0x86/0x9F).
REQ-024 After lane rate-1 written (ABSORB or PAD): PERM, perm_start pulsed on the first PERM cycle only; wait for perm_done.
REQ-025 perm_done in PERM: ->ABSORB with lane_idx=0 if words or padding remain, else ->FIN; a full final block of message (k==0, W multiple of rate) requires an extra pad-only block.
REQ-026 FIN: done pulses one cycle, busy drops same cycle, ->IDLE.
REQ-027 perm_done outside PERM ignored; start while busy ignored.
REQ-028 Word count and lane index counters wrap-free: word counter 13 bits, lane_idx resets to 0 per block.

Reset
REQ-029 rst_n low: state IDLE, all outputs 0 (lane_idx 0, lane_data 0), counters cleared, latched mode/msg_len cleared.
REQ-030 Reset mid-operation aborts message; no further fifo_rd_en or perm_start; FIFO contents not drained.

Configuration
REQ-031 Macro SHA3_ABSORB_SHAKE_EN defined: modes 4,5 supported per REQ-018/019.
REQ-032 Undefined: start with mode 4..7 rejected, err pulses, state stays IDLE; modes 6,7 always rejected.

Verification
REQ-033 SHA3-256, msg_len=0 -> no fifo_rd_en; lane0=0x06, lanes1-15=0, lane16=0x8000000000000000; one perm_start; done after perm_done.
REQ-034 SHA3-256, msg_len=3, word 0xFFFFFFFFFF332211 -> lane0=0x0000000006332211, lane16=0x8000000000000000.
REQ-035 SHA3-512, msg_len=72 (9 words) -> block1 nine FIFO lanes, perm; block2 lane0=0x06, lane8=0x8000000000000000; two perm_start, one done.
REQ-036 SHA3-512, msg_len=71 -> lane8 byte7=0x86, single perm_start.
REQ-037 FIFO empty for 5 cycles mid-ABSORB -> no lane_wr_en/fifo_rd_en during gap; rst_n low mid-ABSORB -> busy=0 immediately, no further reads.
REQ-038 mode=4, msg_len=0: with macro -> lane0=0x1F, lane20=0x8000000000000000; without macro -> err pulse, busy stays 0.

Source files
------------

// File: rtl/sha3_absorb_ctrl.sv
// SHA-3 absorb/pad controller: streams FIFO words into rate lanes, pads, and sequences Keccak-f.
// Optional SHAKE128/SHAKE256 support is enabled by defining SHA3_ABSORB_SHAKE_EN.
module sha3_absorb_ctrl #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [15:0]          msg_len,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 lane_wr_en,
  output logic [4:0]           lane_idx,
  output logic [DATA_SIZE-1:0] lane_data,
  output logic                 perm_start,
  input  logic                 perm_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    PAD    = 3'd2,
    PERM   = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  mode_r, mode_s;
  logic [15:0] len_r, len_s;
  logic [12:0] word_cnt_r, word_cnt_s;
  logic [4:0]  lane_r, lane_s;
  logic        msg_done_r, msg_done_s;
  logic        d_placed_r, d_placed_s;
  logic        pad_done_r, pad_done_s;
  logic        perm_issued_r, perm_issued_s;
  logic        err_r, err_s;

  logic [4:0]  rate_m1_s;
  logic [7:0]  domain_s;
  logic [2:0]  tail_k_s;
  logic [12:0] last_idx_s;
  logic        last_word_s;

  function automatic logic mode_ok(input logic [2:0] m);
    case (m)
      3'd0, 3'd1, 3'd2, 3'd3: mode_ok = 1'b1;
`ifdef SHA3_ABSORB_SHAKE_EN
      3'd4, 3'd5:             mode_ok = 1'b1;
`endif
      default:                mode_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] rate_m1(input logic [2:0] m);
    case (m)
      3'd0:    rate_m1 = 5'd17;
      3'd1:    rate_m1 = 5'd16;
      3'd2:    rate_m1 = 5'd12;
      3'd3:    rate_m1 = 5'd8;
      3'd4:    rate_m1 = 5'd20;
      3'd5:    rate_m1 = 5'd16;
      default: rate_m1 = 5'd16;
    endcase
  endfunction

  // Keep bytes below k, place the domain byte at k, clear the rest.
  function automatic logic [DATA_SIZE-1:0] tail_lane(input logic [DATA_SIZE-1:0] w,
                                                     input logic [2:0] k,
                                                     input logic [7:0] d);
    tail_lane = '0;
    for (int b = 0; b < 8; b++) begin
      if (3'(b) < k) begin
        tail_lane[8*b +: 8] = w[8*b +: 8];
      end else if (3'(b) == k) begin
        tail_lane[8*b +: 8] = d;
      end else begin
        tail_lane[8*b +: 8] = 8'h00;
      end
    end
  endfunction

  assign rate_m1_s   = rate_m1(mode_r);
  assign domain_s    = mode_r[2] ? 8'h1F : 8'h06;
  assign tail_k_s    = len_r[2:0];
  assign last_idx_s  = len_r[15:3] - {12'd0, (tail_k_s == 3'd0)};
  assign last_word_s = (word_cnt_r == last_idx_s);

  assign lane_idx = lane_r;
  assign busy     = (state_r == ABSORB) || (state_r == PAD) || (state_r == PERM);
  assign done     = (state_r == FIN);
  assign err      = err_r;

  // Next-state, counter updates and per-cycle strobes.
  always_comb begin
    state_s       = state_r;
    mode_s        = mode_r;
    len_s         = len_r;
    word_cnt_s    = word_cnt_r;
    lane_s        = lane_r;
    msg_done_s    = msg_done_r;
    d_placed_s    = d_placed_r;
    pad_done_s    = pad_done_r;
    perm_issued_s = perm_issued_r;
    err_s         = 1'b0;
    fifo_rd_en    = 1'b0;
    lane_wr_en    = 1'b0;
    lane_data     = '0;
    perm_start    = 1'b0;

    case (state_r)
      IDLE: begin
        if (start && mode_ok(mode)) begin
          mode_s        = mode;
          len_s         = msg_len;
          word_cnt_s    = 13'd0;
          lane_s        = 5'd0;
          msg_done_s    = (msg_len == 16'd0);
          d_placed_s    = 1'b0;
          pad_done_s    = 1'b0;
          perm_issued_s = 1'b0;
          state_s       = (msg_len == 16'd0) ? PAD : ABSORB;
        end else if (start) begin
          err_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      ABSORB: begin
        if (msg_done_r) begin
          state_s = PAD;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          lane_wr_en = 1'b1;
          word_cnt_s = word_cnt_r + 13'd1;
          if (last_word_s && (tail_k_s != 3'd0)) begin
            lane_data  = tail_lane(fifo_rd_data, tail_k_s, domain_s);
            d_placed_s = 1'b1;
          end else begin
            lane_data = fifo_rd_data;
          end
          msg_done_s = last_word_s;
          if (lane_r == rate_m1_s) begin
            // A short final word in the last lane completes the padding here.
            if (last_word_s && (tail_k_s != 3'd0)) begin
              lane_data[DATA_SIZE-1 -: 8] = lane_data[DATA_SIZE-1 -: 8] | 8'h80;
              pad_done_s = 1'b1;
            end else begin
              pad_done_s = 1'b0;
            end
            lane_s  = 5'd0;
            state_s = PERM;
          end else begin
            lane_s  = lane_r + 5'd1;
            state_s = last_word_s ? PAD : ABSORB;
          end
        end else begin
          state_s = ABSORB;
        end
      end

      PAD: begin
        lane_wr_en = 1'b1;
        lane_data  = d_placed_r ? '0 : {{(DATA_SIZE-8){1'b0}}, domain_s};
        d_placed_s = 1'b1;
        if (lane_r == rate_m1_s) begin
          lane_data[DATA_SIZE-1 -: 8] = lane_data[DATA_SIZE-1 -: 8] | 8'h80;
          pad_done_s = 1'b1;
          lane_s     = 5'd0;
          state_s    = PERM;
        end else begin
          lane_s  = lane_r + 5'd1;
          state_s = PAD;
        end
      end

      PERM: begin
        perm_start    = !perm_issued_r;
        perm_issued_s = 1'b1;
        if (perm_done) begin
          perm_issued_s = 1'b0;
          lane_s        = 5'd0;
          state_s       = pad_done_r ? FIN : ABSORB;
        end else begin
          state_s = PERM;
        end
      end

      FIN: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mode_r        <= 3'd0;
      len_r         <= 16'd0;
      word_cnt_r    <= 13'd0;
      lane_r        <= 5'd0;
      msg_done_r    <= 1'b0;
      d_placed_r    <= 1'b0;
      pad_done_r    <= 1'b0;
      perm_issued_r <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      mode_r        <= mode_s;
      len_r         <= len_s;
      word_cnt_r    <= word_cnt_s;
      lane_r        <= lane_s;
      msg_done_r    <= msg_done_s;
      d_placed_r    <= d_placed_s;
      pad_done_r    <= pad_done_s;
      perm_issued_r <= perm_issued_s;
      err_r         <= err_s;
    end
  end

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Scoreboard bench for sha3_absorb_ctrl: expected lane writes, perm_start, done and err
// events are queued by the stimulus and popped by an independent output monitor.
module tb_sha3_absorb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] msg_len = 16'd0;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_rd_data = 64'd0;
  logic        fifo_rd_en;
  logic        lane_wr_en;
  logic [4:0]  lane_idx;
  logic [63:0] lane_data;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  localparam logic [63:0] TOP = 64'h8000_0000_0000_0000;
  localparam int K_LANE = 0, K_PERM = 1, K_DONE = 2, K_ERR = 3, K_RDONLY = 4;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] data;
    logic        rd;
  } evt_t;

  evt_t        exp_q[$];
  logic [63:0] fifo_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  sha3_absorb_ctrl #(.DATA_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .msg_len(msg_len),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .lane_wr_en(lane_wr_en), .lane_idx(lane_idx), .lane_data(lane_data),
    .perm_start(perm_start), .perm_done(perm_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_evt(input int kind, input int idx, input logic [63:0] data, input logic rd);
    evt_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d data=%h rd=%b, required no event", kind, idx, data, rd);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.data !== data || e.rd !== rd) begin
        miscompares++;
        $display("FAIL event_seq: got kind=%0d idx=%0d data=%h rd=%b, required kind=%0d idx=%0d data=%h rd=%b",
                 kind, idx, data, rd, e.kind, e.idx, e.data, e.rd);
      end
    end
  endtask

  // Output monitor: every observed event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (lane_wr_en) check_evt(K_LANE, int'(lane_idx), lane_data, fifo_rd_en);
      else if (fifo_rd_en) check_evt(K_RDONLY, int'(lane_idx), lane_data, 1'b1);
      if (perm_start) check_evt(K_PERM, 0, 64'd0, 1'b0);
      if (done) check_evt(K_DONE, 0, 64'd0, 1'b0);
      if (err) check_evt(K_ERR, 0, 64'd0, 1'b0);
      if (busy && fifo_empty) begin
        vectors++;
        if (fifo_rd_en !== 1'b0) begin
          miscompares++;
          $display("FAIL rd_while_empty: got fifo_rd_en=%b, required 0", fifo_rd_en);
        end
      end
    end
  end

  // Show-ahead FIFO model.
  initial begin
    logic rd_seen;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd_en && !fifo_empty;
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    end
  end

  // Permutation responder: perm_done three cycles after perm_start.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (perm_start) cnt = 3;
      @(posedge clk);
      #1;
      perm_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) perm_done = 1'b1;
      end
    end
  end

  task automatic exp_lane(input int idx, input logic [63:0] d, input logic rd);
    evt_t e;
    e.kind = K_LANE; e.idx = idx; e.data = d; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic exp_evt(input int kind);
    evt_t e;
    e.kind = kind; e.idx = 0; e.data = 64'd0; e.rd = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_pad(input int from, input int rate, input logic [7:0] dbyte);
    logic [63:0] d;
    for (int i = from; i < rate; i++) begin
      d = (i == from) ? {56'd0, dbyte} : 64'd0;
      if (i == rate - 1) d = d | TOP;
      exp_lane(i, d, 1'b0);
    end
  endtask

  task automatic do_start(input logic [2:0] m, input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1; mode = m; msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic [15:0] len);
    start = 1'b1; mode = m; msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d events pending busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [63:0] w;
    int cnt;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, err, fifo_rd_en, lane_wr_en, perm_start, lane_idx} !== 11'd0 || lane_data !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b ps=%b idx=%0d data=%h, required all 0",
               busy, done, err, fifo_rd_en, lane_wr_en, perm_start, lane_idx, lane_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SHA3-256, empty message.
    exp_pad(0, 17, 8'h06); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd1, 16'd0);
    wait_drain("sha256_len0");

    // SHA3-256, 3-byte message.
    fifo_q.push_back(64'hFFFF_FFFF_FF33_2211);
    exp_lane(0, 64'h0000_0000_0633_2211, 1'b1); exp_pad(1, 17, 8'h00);
    exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd1, 16'd3);
    wait_drain("sha256_len3");

    // SHA3-512, exactly one full block: extra pad-only block; starts while busy ignored.
    for (int i = 0; i < 9; i++) begin
      w = 64'hC0DE_0000_0000_0000 + 64'(i);
      fifo_q.push_back(w);
      exp_lane(i, w, 1'b1);
    end
    exp_evt(K_PERM); exp_pad(0, 9, 8'h06); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd3, 16'd72);
    repeat (3) @(posedge clk); #1;
    pulse_start(3'd6, 16'd0);
    repeat (8) @(posedge clk); #1;
    pulse_start(3'd0, 16'd0);
    wait_drain("sha512_len72");

    // SHA3-512, 71 bytes: domain and final bit share byte 7 of lane 8.
    for (int i = 0; i < 8; i++) begin
      w = 64'h5A5A_0000_0000_0000 + 64'(i);
      fifo_q.push_back(w);
      exp_lane(i, w, 1'b1);
    end
    fifo_q.push_back(64'h1122_3344_5566_7788);
    exp_lane(8, 64'h8622_3344_5566_7788, 1'b1);
    exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd3, 16'd71);
    wait_drain("sha512_len71");

    // SHA3-256, 20 bytes with the FIFO running dry mid-message.
    fifo_q.push_back(64'h0102_0304_0506_0708);
    exp_lane(0, 64'h0102_0304_0506_0708, 1'b1);
    exp_lane(1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    exp_lane(2, 64'h0000_0006_4433_2211, 1'b1);
    exp_pad(3, 17, 8'h00); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd1, 16'd20);
    repeat (7) @(posedge clk); #1;
    fifo_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    fifo_q.push_back(64'hAABB_CCDD_4433_2211);
    wait_drain("sha256_gap");

    // SHA3-224, 16 bytes: k==0, domain byte opens the next lane.
    fifo_q.push_back(64'h1111_1111_1111_1111);
    fifo_q.push_back(64'h2222_2222_2222_2222);
    exp_lane(0, 64'h1111_1111_1111_1111, 1'b1);
    exp_lane(1, 64'h2222_2222_2222_2222, 1'b1);
    exp_pad(2, 18, 8'h06); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd0, 16'd16);
    wait_drain("sha224_len16");

    // SHA3-384, 8 bytes.
    fifo_q.push_back(64'h0F0E_0D0C_0B0A_0908);
    exp_lane(0, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
    exp_pad(1, 13, 8'h06); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd2, 16'd8);
    wait_drain("sha384_len8");

    // SHAKE128, empty message.
`ifdef SHA3_ABSORB_SHAKE_EN
    exp_pad(0, 21, 8'h1F); exp_evt(K_PERM); exp_evt(K_DONE);
    do_start(3'd4, 16'd0);
    wait_drain("shake128_len0");
`else
    exp_evt(K_ERR);
    do_start(3'd4, 16'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL shake_reject_busy: got busy high %0d cycles, required 0", cnt);
    end
    wait_drain("shake128_reject");
`endif

    // Mode 6 is never supported.
    exp_evt(K_ERR);
    do_start(3'd6, 16'd5);
    wait_drain("mode6_reject");

    // Reset in the middle of ABSORB.
    fifo_q.push_back(64'hAAAA_0000_0000_0001);
    fifo_q.push_back(64'hAAAA_0000_0000_0002);
    exp_lane(0, 64'hAAAA_0000_0000_0001, 1'b1);
    exp_lane(1, 64'hAAAA_0000_0000_0002, 1'b1);
    do_start(3'd1, 16'd40);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(posedge clk);
      cnt++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got busy=%b, required 0", busy);
    end
    for (int i = 0; i < 3; i++) fifo_q.push_back(64'hBBBB_0000_0000_0000 + 64'(i));
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_rd_en || perm_start) cnt++;
    end
    vectors++;
    if (cnt != 0) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d read/perm cycles after reset, required 0", cnt);
    end
    vectors++;
    if (fifo_q.size() != 3) begin
      miscompares++;
      $display("FAIL reset_no_drain: got fifo depth %0d, required 3", fifo_q.size());
    end
    fifo_q.delete();
    wait_drain("reset_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
